// File: rtl/cache_bus_mem_responder.sv
// Memory-side responder for the dcache line bus: critical-word-first wrapped line
// bursts and uncached single-word accesses served from a 1-cycle-latency SRAM.
module cache_bus_mem_responder #(
  parameter int LINE_WORDS     = 4,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      breq_valid,
  output logic                      breq_ready,
  input  logic                      breq_write,
  input  logic                      breq_uncached,
  input  logic [31:0]               breq_addr,
  input  logic [3:0]                breq_strb,
  input  logic [31:0]               breq_wdata,
  input  logic                      breq_wvalid,
  input  logic                      breq_wlast,
  output logic                      bresp_wready,
  output logic                      bresp_wdone,
  output logic [31:0]               bresp_rdata,
  output logic                      bresp_rvalid,
  output logic                      bresp_rlast,
  input  logic                      breq_rready,
  output logic                      proto_err_o,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [3:0]                mem_wstrb,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CNT_W = OFF_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WACK} state_e;

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] waddr_q;
  logic                      uncached_q;
  logic [CNT_W-1:0]          beat_q;
  logic [CNT_W-1:0]          pop_q;
  logic                      inflight_q;
  logic [31:0]               fifo_q [2];
  logic                      wr_ptr_q, rd_ptr_q;
  logic [1:0]                count_q, count_d;
  logic                      proto_err_q;

  logic                      accept, pop, issue, wbeat, rlast;
  logic [CNT_W-1:0]          n_beats, last_beat;
  logic [2:0]                occ;
  logic [OFF_W-1:0]          beat_off;
  logic [MEM_ADDR_WIDTH-1:0] beat_addr;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^{breq_addr[31:MEM_ADDR_WIDTH+2], breq_addr[1:0]};

  assign n_beats   = uncached_q ? CNT_W'(1) : CNT_W'(LINE_WORDS);
  assign last_beat = n_beats - CNT_W'(1);

  // Wrap inside the line; an uncached access has beat 0 only, i.e. the exact word.
  assign beat_off  = waddr_q[OFF_W-1:0] + beat_q[OFF_W-1:0];
  assign beat_addr = {waddr_q[MEM_ADDR_WIDTH-1:OFF_W], beat_off};

  assign accept       = breq_valid & breq_ready;
  assign bresp_rvalid = (count_q != 2'd0);
  assign bresp_rdata  = fifo_q[rd_ptr_q];
  assign rlast        = bresp_rvalid & (pop_q == last_beat);
  assign bresp_rlast  = rlast;
  assign pop          = bresp_rvalid & breq_rready;
  assign proto_err_o  = proto_err_q;

  // Occupancy after this cycle's pop must leave room for the beat about to be issued.
  assign occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = (state_q == S_RD) && (beat_q != n_beats) && (occ < 3'd2);
  assign wbeat   = (state_q == S_WR) && breq_wvalid;
  assign count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = breq_write ? S_WR : S_RD;
      S_RD:   if (pop && rlast) state_d = S_IDLE;
      S_WR:   if (wbeat && (beat_q == last_beat)) state_d = S_WACK;
      S_WACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    breq_ready   = 1'b0;
    bresp_wready = 1'b0;
    bresp_wdone  = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_wstrb    = 4'h0;
    mem_addr     = '0;
    mem_wdata    = 32'h0;
    unique case (state_q)
      S_IDLE: breq_ready = ~rst;
      S_RD: begin
        if (issue) begin
          mem_en   = 1'b1;
          mem_addr = beat_addr;
        end
      end
      S_WR: begin
        bresp_wready = 1'b1;
        if (breq_wvalid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = beat_addr;
          mem_wdata = breq_wdata;
          mem_wstrb = uncached_q ? breq_strb : 4'hF;
        end
      end
      S_WACK: bresp_wdone = 1'b1;
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    fifo_q[gi] <= 32'h0;
      else if (inflight_q && (wr_ptr_q == 1'(gi))) fifo_q[gi] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q     <= '0;
      uncached_q  <= 1'b0;
      beat_q      <= '0;
      pop_q       <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      proto_err_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      count_q    <= count_d;
      if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        pop_q    <= pop_q + CNT_W'(1);
      end
      if (accept) begin
        waddr_q    <= breq_addr[MEM_ADDR_WIDTH+1:2];
        uncached_q <= breq_uncached;
        beat_q     <= '0;
        pop_q      <= '0;
      end else if (issue || wbeat) begin
        beat_q <= beat_q + CNT_W'(1);
      end
      if (wbeat && (breq_wlast != (beat_q == last_beat))) proto_err_q <= 1'b1;
    end
  end

endmodule

// File: doc/cache_bus_mem_responder.md
# cache_bus_mem_responder

Memory-side responder for the data-cache line bus. It accepts line refills, line writebacks and uncached single-word accesses issued by the LSU/dcache. It serves them from a synchronous single-port backing SRAM with 1-cycle read latency, delivering critical-word-first wrapped bursts. It sits between the dcache bus request/response ports and the on-chip memory or memory-controller front end.

## Interface
- LINE_WORDS, 4, words per cache line (power of two, 2..16); line burst length
- MEM_ADDR_WIDTH, 16, backing-memory word-address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- breq_valid  in  1  request valid
- breq_ready  out  1  request accepted when valid&ready
- breq_write  in  1  1 = write, 0 = read
- breq_uncached  in  1  1 = single word, 0 = line burst
- breq_addr  in  32  byte address; word index = [MEM_ADDR_WIDTH+1:2]
- breq_strb  in  4  byte strobes, uncached writes only
- breq_wdata  in  32  write beat data
- breq_wvalid  in  1  write beat valid
- breq_wlast  in  1  initiator's last-beat marker (checked only)
- bresp_wready  out  1  write beat accepted when wvalid&wready
- bresp_wdone  out  1  one-cycle write-complete pulse
- bresp_rdata  out  32  read beat data
- bresp_rvalid  out  1  read beat valid
- bresp_rlast  out  1  last read beat
- breq_rready  in  1  initiator accepts read beat
- proto_err_o  out  1  sticky wlast-mismatch flag, cleared only by rst
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_wstrb  out  4  SRAM byte enables
- mem_addr  out  MEM_ADDR_WIDTH  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en&~mem_we

## Operation
- States: IDLE, RD, WR, WACK. breq_ready = (state==IDLE) & ~rst.
- Accept in IDLE: latch addr, write and uncached. Burst length N = uncached ? 1 : LINE_WORDS. Start offset s = addr word bits [log2(LINE_WORDS)+1:2].
- Beat i address = {line base, (s+i) mod LINE_WORDS}. Uncached uses the exact word. Wrap-around is within the line only.
- IDLE -> RD (read) or WR (write) on handshake.
- RD: 2-entry output FIFO plus one in-flight flag.
  - Issue a read when beats remain and (count + inflight − (rvalid&rready)) < 2.
  - Returning mem_rdata is pushed into the FIFO.
  - bresp_rvalid = FIFO non-empty; bresp_rdata = FIFO head.
  - bresp_rlast = head is beat N−1.
  - RD -> IDLE on the rlast handshake.
- WR: bresp_wready = 1.
  - Each wvalid beat writes mem_addr(beat i) combinationally in the same cycle.
  - Strobes: breq_strb if uncached, else 4'hF.
  - Beat counter alone ends the burst. At the beat N−1 handshake -> WACK.
  - proto_err_o is set if wlast=1 on any beat ≠ N−1, or wlast=0 on beat N−1.
- WACK: bresp_wdone=1 for exactly one cycle -> IDLE.
- A mem write and a mem read are never issued in the same cycle (exclusive states).
- Reset (any time, including mid-burst): state IDLE, FIFO flushed, in-flight flag cleared, counters cleared. An in-flight mem_rdata arriving after reset is discarded.

## Timing
- Reset values: breq_ready 0 while rst is high, then 1. All other outputs 0. mem_addr and mem_wdata are 0.
- Read with handshake at cycle T:
  - first mem_en at T+1; first bresp_rvalid at T+3.
  - With rready held high, one beat per cycle; rlast at T+2+N.
  - breq_ready high again at T+3+N.
- rready low: rvalid and rdata held stable. At most 2 buffered beats plus 1 in flight; issue stalls while full. No beat is lost or duplicated.
- Write with handshake at T: wready high from T+1. Beat at cycle W writes the SRAM in cycle W. Last beat at cycle L gives wdone at L+1 and breq_ready at L+2.
- breq_* address and control inputs are ignored outside IDLE. wvalid is ignored outside WR.

## Test plan
- Line read, LINE_WORDS=4, addr 0x100, mem[0x40..0x43]=A,B,C,D, rready=1 -> beats A,B,C,D on T+3..T+6, rlast with D, breq_ready at T+7.
- Wrapped read, addr 0x108 -> mem_addr order 0x42,0x43,0x40,0x41; data C,D,A,B; rlast with B.
- Backpressure: rready pattern 1,0,0,1,0,1,1 during line read -> in-order A..D, no duplicates, no more than 2 buffered, rdata stable while stalled.
- Uncached write, addr 0x204, strb 4'b0101, wdata 0xAABBCCDD -> one SRAM write at 0x81 with wstrb 0101, wdone one cycle later, proto_err_o stays 0.
- Line write of 4 beats with wlast on beat 2 -> all 4 beats written, wdone after beat 3, proto_err_o=1 until rst.
- Assert rst during beat 2 of a line read -> outputs reset asynchronously; after release breq_ready=1, rvalid=0. A new read returns correct data with no stale beat.
